tank_ctrl_multi: RTL
====================

TANK_CTRL_MULTI -- requirements
Module: tank_ctrl_multi

Interface
REQ-001 Parameter N_PUMPS, default 2, number of pumps; legal range 2..8.
REQ-002 Parameter DEBOUNCE, default 4, cycles a raw sensor change must stay stable before it is accepted; legal range 1..255.
REQ-003 Parameter MIN_ON, default 8, minimum cycles a pump stays on once switched on; legal range 1..255.
REQ-004 clk  input  1  single system clock, rising-edge active.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 I  input  1  lower level sensor, 1 = liquid at or above the lower mark.
REQ-007 S  input  1  upper level sensor, 1 = liquid at or above the upper mark.
REQ-008 B  output  N_PUMPS  pump enables, bit k = pump k on.
REQ-009 lead  output  max($clog2(N_PUMPS),1)  index of the current lead pump.
REQ-010 fault  output  1  1 = inconsistent sensors (S=1, I=0) accepted.

Function
REQ-011 Each sensor SHALL have a debounce filter: the debounced value Id/Sd updates on the DEBOUNCE-th consecutive rising edge at which raw differs from it; any return to the debounced value restarts the count.
REQ-012 The state machine SHALL have the states FULL, HALF, EMPTY and FAULT, and SHALL update one edge after the debounced values change.
REQ-013 Next state from any state SHALL be: Id=1,Sd=1 -> FULL; Id=1,Sd=0 -> HALF; Id=0,Sd=0 -> EMPTY; Id=0,Sd=1 -> FAULT.
REQ-014 Requested pumps SHALL be: FULL none; HALF the lead pump only; EMPTY all pumps; FAULT none.
REQ-015 B SHALL be a Moore decode of the state register and the per-pump hold counters, with no combinational path from I or S.
REQ-016 Total latency SHALL be DEBOUNCE+1 rising edges from a stable raw change to the change on B.
REQ-017 Each pump SHALL have a hold counter loaded with MIN_ON when its request rises from 0 to 1, decremented each cycle while nonzero.
REQ-018 The hold counter SHALL saturate at 0.
REQ-019 B[k] SHALL equal request[k] OR (hold[k] != 0).
REQ-020 On entry to FAULT, all hold counters SHALL clear in the same edge, so that B = 0 and fault = 1 together.
REQ-021 FAULT SHALL exit only through REQ-013 once the debounced sensors are consistent; fault SHALL be 1 exactly while in FAULT.
REQ-022 The lead index SHALL advance by 1 modulo N_PUMPS on every transition into FULL from HALF or EMPTY; FULL->FULL and FAULT->FULL SHALL NOT advance it.
REQ-023 A re-request of a pump that is still held SHALL reload its counter to MIN_ON.

Reset
REQ-024 While reset=0 the block SHALL hold, asynchronously: state=FULL, Id=1, Sd=1, debounce counters=0, hold counters=0, lead=0, B=0, fault=0.
REQ-025 Reset asserted mid-operation SHALL force B=0 immediately, without waiting for MIN_ON.
REQ-026 After reset is released, the block SHALL start from the REQ-024 values and apply REQ-011 to the live sensors.

Configuration
REQ-027 Macro TANK_ROTATE_EN: when defined, lead rotation per REQ-022 SHALL be compiled in.
REQ-028 When TANK_ROTATE_EN is undefined, lead SHALL be constant 0, pump 0 SHALL always be the HALF pump, and no rotation logic SHALL be synthesised.

Verification (defaults, TANK_ROTATE_EN defined)
REQ-029 Reset held, then released with I=S=0 held -> B=00 until the 5th edge after release, then B=11, lead=0.
REQ-030 From FULL, pulse I=0 for 3 cycles -> B stays 00, no state change.
REQ-031 EMPTY for 20 cycles, then I=1 -> after 5 edges B=01; raise S -> after 5 edges B=00 and lead=1.
REQ-032 From the REQ-031 end state, S=0 -> B=10 (pump 1 leads).
REQ-033 EMPTY entered, then I=1 after 2 cycles -> B=11 persists until pump 1 has been on for 8 cycles, then B=01.
REQ-034 EMPTY, then S=1 with I=0 -> 5 edges later fault=1 and B=00 in the same cycle; then I=1 -> FULL, fault=0, lead unchanged.

Source files
------------

// File: rtl/tank_ctrl_multi.sv
// Tank level controller driving N_PUMPS pumps from two debounced level sensors.
//
// Ports:
//   clk    - system clock, rising-edge active
//   reset  - asynchronous active-low reset
//   I      - lower level sensor (1 = liquid at or above lower mark)
//   S      - upper level sensor (1 = liquid at or above upper mark)
//   B      - pump enables, bit k = pump k on
//   lead   - index of the pump used when the tank is half full
//   fault  - 1 while the debounced sensors are inconsistent (S=1, I=0)
//
// Build option: define TANK_ROTATE_EN to rotate the lead pump on every fill
// completion (HALF/EMPTY -> FULL). Without it the lead is fixed at pump 0.

module tank_ctrl_multi #(
  parameter int unsigned N_PUMPS  = 2,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned MIN_ON   = 8,
  localparam int unsigned LW      = (N_PUMPS > 1) ? $clog2(N_PUMPS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               I,
  input  logic               S,
  output logic [N_PUMPS-1:0] B,
  output logic [LW-1:0]      lead,
  output logic               fault
);

  typedef enum logic [1:0] {StFull, StHalf, StEmpty, StFault} state_e;

  localparam logic [7:0] DebLast = 8'(DEBOUNCE - 1);
  localparam logic [7:0] MinOn   = 8'(MIN_ON);

  state_e state_q, state_d;
  logic   id_q, id_d, sd_q, sd_d;
  logic [7:0] cnt_i_q, cnt_i_d, cnt_s_q, cnt_s_d;
  logic [N_PUMPS-1:0][7:0] hold_q, hold_d;
  logic [LW-1:0] lead_q, lead_d;
  logic [N_PUMPS-1:0] req_q, req_d;

  // Pumps requested by a given state; only the lead pump runs when half full.
  function automatic logic [N_PUMPS-1:0] req_of(input state_e st, input logic [LW-1:0] ld);
    logic [N_PUMPS-1:0] r;
    r = '0;
    case (st)
      StHalf:  r = N_PUMPS'(1) << ld;
      StEmpty: r = '1;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Debounce: accept a raw value only after DEBOUNCE consecutive differing edges.
  always_comb begin
    id_d    = id_q;
    cnt_i_d = '0;
    if (I != id_q) begin
      if (cnt_i_q == DebLast) id_d = I;
      else                    cnt_i_d = cnt_i_q + 8'd1;
    end
    sd_d    = sd_q;
    cnt_s_d = '0;
    if (S != sd_q) begin
      if (cnt_s_q == DebLast) sd_d = S;
      else                    cnt_s_d = cnt_s_q + 8'd1;
    end
  end

  // State follows the registered debounced sensors, one edge behind them.
  always_comb begin
    state_d = state_q;
    case ({id_q, sd_q})
      2'b11:   state_d = StFull;
      2'b10:   state_d = StHalf;
      2'b00:   state_d = StEmpty;
      default: state_d = StFault;
    endcase
  end

`ifdef TANK_ROTATE_EN
  // Advance the lead only when a fill completes; FULL->FULL and FAULT->FULL keep it.
  always_comb begin
    lead_d = lead_q;
    if (state_d == StFull && (state_q == StHalf || state_q == StEmpty)) begin
      lead_d = (lead_q == LW'(N_PUMPS - 1)) ? '0 : lead_q + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lead_q <= '0;
    else        lead_q <= lead_d;
  end
`else
  assign lead_q = '0;
  assign lead_d = '0;
`endif

  assign req_q = req_of(state_q, lead_q);
  assign req_d = req_of(state_d, lead_d);

  // Hold counters load on a request rising edge (also reloading a still-held
  // pump) and are wiped on FAULT so B drops in the same edge fault rises.
  always_comb begin
    hold_d = hold_q;
    for (int unsigned k = 0; k < N_PUMPS; k++) begin
      if (state_d == StFault)           hold_d[k] = '0;
      else if (req_d[k] && !req_q[k])   hold_d[k] = MinOn;
      else if (hold_q[k] != 8'd0)       hold_d[k] = hold_q[k] - 8'd1;
      else                              hold_d[k] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFull;
      id_q    <= 1'b1;
      sd_q    <= 1'b1;
      cnt_i_q <= '0;
      cnt_s_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      sd_q    <= sd_d;
      cnt_i_q <= cnt_i_d;
      cnt_s_q <= cnt_s_d;
      hold_q  <= hold_d;
    end
  end

  // Moore outputs: registered state, lead and hold counters only.
  always_comb begin
    B = '0;
    for (int unsigned k = 0; k < N_PUMPS; k++) begin
      B[k] = req_q[k] | (hold_q[k] != 8'd0);
    end
  end

  assign lead  = lead_q;
  assign fault = (state_q == StFault);

endmodule
